// File: rtl/approx_pkg.sv
// Shared definitions for the pipelined approximate adder: default geometry,
// k clamping and the per-bit approximate-region mask.
package approx_pkg;

  localparam int N_DEF       = 32;
  localparam int STAGE_W_DEF = 8;
  localparam int STAGES      = N_DEF / STAGE_W_DEF;
  localparam int K_W         = $clog2(N_DEF + 1);

  function automatic int clamp_k(input int k, input int n);
    return (k > n) ? n : k;
  endfunction

  // Bit j of the slice starting at absolute bit 'base' lies in the OR region.
  function automatic logic approx_mask_bit(input int base, input int j, input int k);
    return (base + j) < k;
  endfunction

endpackage

// File: rtl/approx_adder_slice.sv
// One STAGE_W-bit combinational slice: OR/AND approximation below k,
// ripple full adders at and above k.
module approx_adder_slice
  import approx_pkg::*;
#(
  parameter int W  = 8,
  parameter int KW = 6
) (
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  input  logic          c_in,
  input  logic [KW-1:0] base,
  input  logic [KW-1:0] k,
  output logic [W-1:0]  sum,
  output logic          c_out
);

  always_comb begin
    logic c;
    c   = c_in;
    sum = '0;
    for (int j = 0; j < W; j++) begin
      if (approx_mask_bit(int'(base), j, int'(k))) begin
        sum[j] = a[j] | b[j];
        // Only the top approximate bit launches a carry into the exact part.
        c = ((int'(base) + j + 1) == int'(k)) ? (a[j] & b[j]) : 1'b0;
      end else begin
        sum[j] = a[j] ^ b[j] ^ c;
        c      = (a[j] & b[j]) | (c & (a[j] ^ b[j]));
      end
    end
    c_out = c;
  end

endmodule

// File: rtl/approx_pipe_adder.sv
// Pipelined approximate add/sub, one slice per stage, with an exact shadow
// for error flagging, global-stall valid/ready flow and saturating counters.
module approx_pipe_adder
  import approx_pkg::*;
#(
  parameter int N       = 32,
  parameter int STAGE_W = 8,
  parameter int CNT_W   = 16,
  localparam int KW     = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_a,
  input  logic [N-1:0]     in_b,
  input  logic             in_sub,
  input  logic [KW-1:0]    in_k,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_sum,
  output logic             out_cout,
  output logic             out_err,
  input  logic             clr_stats,
  output logic [CNT_W-1:0] txn_count,
  output logic [CNT_W-1:0] err_count
);

  localparam int ST = N / STAGE_W;

  logic            advance;
  logic [N-1:0]    b_eff;
  logic [KW-1:0]   k_eff;

  // Stage inputs (stage 0 from the ports, stage s from pipe register s-1)
  logic            st_vld [ST];
  logic [N-1:0]    st_a   [ST];
  logic [N-1:0]    st_b   [ST];
  logic [KW-1:0]   st_k   [ST];
  logic            st_ca  [ST];
  logic            st_ce  [ST];
  logic [N-1:0]    st_sum [ST];
  logic            st_err [ST];

  logic [STAGE_W-1:0] sl_sa [ST];
  logic [STAGE_W-1:0] sl_se [ST];
  logic               sl_ca [ST];
  logic               sl_ce [ST];

  logic            vld_d [ST-1], vld_q [ST-1];
  logic [N-1:0]    a_d   [ST-1], a_q   [ST-1];
  logic [N-1:0]    b_d   [ST-1], b_q   [ST-1];
  logic [KW-1:0]   k_d   [ST-1], k_q   [ST-1];
  logic            ca_d  [ST-1], ca_q  [ST-1];
  logic            ce_d  [ST-1], ce_q  [ST-1];
  logic [N-1:0]    sum_d [ST-1], sum_q [ST-1];
  logic            err_d [ST-1], err_q [ST-1];

  logic             out_valid_d, out_valid_q;
  logic [N-1:0]     out_sum_d, out_sum_q;
  logic             out_cout_d, out_cout_q;
  logic             out_err_d, out_err_q;
  logic [CNT_W-1:0] txn_d, txn_q, errc_d, errc_q;

  assign advance  = !out_valid_q || out_ready;
  assign in_ready = advance;
  assign b_eff    = in_sub ? (~in_b + N'(1)) : in_b;
  assign k_eff    = KW'(clamp_k(int'(in_k), N));

  always_comb begin
    st_vld[0] = in_valid;
    st_a[0]   = in_a;
    st_b[0]   = b_eff;
    st_k[0]   = k_eff;
    st_ca[0]  = 1'b0;
    st_ce[0]  = 1'b0;
    st_sum[0] = '0;
    st_err[0] = 1'b0;
    for (int s = 1; s < ST; s++) begin
      st_vld[s] = vld_q[s-1];
      st_a[s]   = a_q[s-1];
      st_b[s]   = b_q[s-1];
      st_k[s]   = k_q[s-1];
      st_ca[s]  = ca_q[s-1];
      st_ce[s]  = ce_q[s-1];
      st_sum[s] = sum_q[s-1];
      st_err[s] = err_q[s-1];
    end
  end

  for (genvar s = 0; s < ST; s++) begin : g_slice
    approx_adder_slice #(.W(STAGE_W), .KW(KW)) u_apx (
      .a     (st_a[s][s*STAGE_W +: STAGE_W]),
      .b     (st_b[s][s*STAGE_W +: STAGE_W]),
      .c_in  (st_ca[s]),
      .base  (KW'(s * STAGE_W)),
      .k     (st_k[s]),
      .sum   (sl_sa[s]),
      .c_out (sl_ca[s])
    );
    approx_adder_slice #(.W(STAGE_W), .KW(KW)) u_exact (
      .a     (st_a[s][s*STAGE_W +: STAGE_W]),
      .b     (st_b[s][s*STAGE_W +: STAGE_W]),
      .c_in  (st_ce[s]),
      .base  (KW'(s * STAGE_W)),
      .k     ('0),
      .sum   (sl_se[s]),
      .c_out (sl_ce[s])
    );
  end

  always_comb begin
    for (int s = 0; s < ST - 1; s++) begin
      vld_d[s] = st_vld[s];
      a_d[s]   = st_a[s];
      b_d[s]   = st_b[s];
      k_d[s]   = st_k[s];
      ca_d[s]  = sl_ca[s];
      ce_d[s]  = sl_ce[s];
      sum_d[s] = st_sum[s];
      sum_d[s][s*STAGE_W +: STAGE_W] = sl_sa[s];
      err_d[s] = st_err[s] | (sl_sa[s] != sl_se[s]);
    end
    out_valid_d = st_vld[ST-1];
    out_sum_d   = st_sum[ST-1];
    out_sum_d[(ST-1)*STAGE_W +: STAGE_W] = sl_sa[ST-1];
    out_cout_d  = sl_ca[ST-1];
    out_err_d   = st_err[ST-1] | (sl_sa[ST-1] != sl_se[ST-1]) | (sl_ca[ST-1] != sl_ce[ST-1]);

    // Clear takes priority over a coincident handshake.
    txn_d  = txn_q;
    errc_d = errc_q;
    if (clr_stats) begin
      txn_d  = '0;
      errc_d = '0;
    end else if (out_valid_q && out_ready) begin
      if (txn_q != '1) txn_d = txn_q + CNT_W'(1);
      if (out_err_q && (errc_q != '1)) errc_d = errc_q + CNT_W'(1);
    end
  end

  // Control and visible outputs: reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q       <= '{default: 1'b0};
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_cout_q  <= 1'b0;
      out_err_q   <= 1'b0;
      txn_q       <= '0;
      errc_q      <= '0;
    end else begin
      txn_q  <= txn_d;
      errc_q <= errc_d;
      if (advance) begin
        vld_q       <= vld_d;
        out_valid_q <= out_valid_d;
        out_sum_q   <= out_sum_d;
        out_cout_q  <= out_cout_d;
        out_err_q   <= out_err_d;
      end
    end
  end

  // Skew datapath: qualified by the valid bits, no reset needed
  always_ff @(posedge clk) begin
    if (advance) begin
      a_q   <= a_d;
      b_q   <= b_d;
      k_q   <= k_d;
      ca_q  <= ca_d;
      ce_q  <= ce_d;
      sum_q <= sum_d;
      err_q <= err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_cout  = out_cout_q;
  assign out_err   = out_err_q;
  assign txn_count = txn_q;
  assign err_count = errc_q;

endmodule

// File: tb/tb_approx_pipe_adder.sv
// Randomised and directed bench for approx_pipe_adder against an arithmetic
// reference model with a per-cycle scoreboard.
module tb_approx_pipe_adder;

  localparam int N  = 32;
  localparam int SW = 8;
  localparam int CW = 4;
  localparam int KW = 6;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_a;
  logic [N-1:0]  in_b;
  logic          in_sub;
  logic [KW-1:0] in_k;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_sum;
  logic          out_cout;
  logic          out_err;
  logic          clr_stats;
  logic [CW-1:0] txn_count;
  logic [CW-1:0] err_count;

  approx_pipe_adder #(.N(N), .STAGE_W(SW), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sub    (in_sub),
    .in_k      (in_k),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_err   (out_err),
    .clr_stats (clr_stats),
    .txn_count (txn_count),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        err;
  } res_t;

  int   total = 0;
  int   bad   = 0;
  res_t exp_q[$];
  int   m_txn = 0;
  int   m_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Approximate result: OR below k, single AND carry from bit k-1, exact add above.
  function automatic res_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic sub, input int k);
    longint unsigned bp, lmask, low, hi, apx, ex, aa;
    logic  c;
    int    kk;
    res_t  r;
    aa    = {32'h0, a};
    bp    = sub ? ((64'h1_0000_0000 - {32'h0, b}) & 64'hFFFF_FFFF) : {32'h0, b};
    kk    = (k > N) ? N : k;
    lmask = (64'd1 << kk) - 64'd1;
    low   = (aa | bp) & lmask;
    c     = 1'b0;
    if (kk > 0) c = aa[kk-1] & bp[kk-1];
    hi    = (aa >> kk) + (bp >> kk) + {63'h0, c};
    apx   = (hi << kk) | low;
    ex    = aa + bp;
    r.sum  = apx[31:0];
    r.cout = apx[32];
    r.err  = (apx[32:0] != ex[32:0]);
    return r;
  endfunction

  logic        hold_vld = 1'b0;
  logic [31:0] hold_sum;
  logic        hold_cout;
  logic        hold_err;
  res_t        exp_e;

  // Scoreboard: every falling edge
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", {out_cout, out_err, out_sum}, 0);
      chk("rst_counts", {txn_count, err_count}, 0);
      chk("rst_in_ready", in_ready, 1);
      exp_q.delete();
      m_txn    = 0;
      m_err    = 0;
      hold_vld = 1'b0;
    end else begin
      if (hold_vld)
        chk("stall_stable", {out_cout, out_err, out_sum}, {hold_cout, hold_err, hold_sum});
      chk("in_ready", in_ready, (!out_valid || out_ready));
      chk("txn_count", txn_count, m_txn);
      chk("err_count", err_count, m_err);
      exp_e.err = 1'b0;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", out_valid, 0);
        end else begin
          exp_e = exp_q.pop_front();
          chk("out_sum", out_sum, exp_e.sum);
          chk("out_cout", out_cout, exp_e.cout);
          chk("out_err", out_err, exp_e.err);
        end
      end
      if (clr_stats) begin
        m_txn = 0;
        m_err = 0;
      end else if (out_valid && out_ready) begin
        if (m_txn < CMAX) m_txn++;
        if (exp_e.err && m_err < CMAX) m_err++;
      end
      if (in_valid && in_ready)
        exp_q.push_back(model(in_a, in_b, in_sub, int'(in_k)));
      hold_vld  = out_valid && !out_ready;
      hold_sum  = out_sum;
      hold_cout = out_cout;
      hold_err  = out_err;
    end
  end

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic sub, input int k);
    in_a     = a;
    in_b     = b;
    in_sub   = sub;
    in_k     = KW'(k);
    in_valid = 1'b1;
  endtask

  task automatic directed(input logic [31:0] a, input logic [31:0] b, input logic sub,
                          input int k, input logic [31:0] es, input logic ec, input logic ee);
    int n;
    drive(a, b, sub, k);
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", n, 4);
    chk("dir_sum", out_sum, es);
    chk("dir_cout", out_cout, ec);
    chk("dir_err", out_err, ee);
    @(posedge clk); #1;
  endtask

  initial begin
    res_t r;
    int   sent, cyc, n;
    logic acc;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_sub    = 1'b0;
    in_k      = '0;
    out_ready = 1'b1;
    clr_stats = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    r = model(32'hFF, 32'h1, 1'b0, 0);
    chk("model_add_k0", {r.cout, r.err, r.sum}, {1'b0, 1'b0, 32'h100});
    r = model(32'hFF, 32'h1, 1'b0, 8);
    chk("model_add_k8", {r.cout, r.err, r.sum}, {1'b0, 1'b1, 32'hFF});
    r = model(32'd10, 32'd3, 1'b1, 0);
    chk("model_sub_k0", {r.cout, r.err, r.sum}, {1'b1, 1'b0, 32'h7});
    r = model(32'd10, 32'd3, 1'b1, 4);
    chk("model_sub_k4", {r.cout, r.err, r.sum}, {1'b1, 1'b1, 32'hF});
    r = model(32'h8000_0001, 32'h8000_0000, 1'b0, 40);
    chk("model_kN", {r.cout, r.err, r.sum}, {1'b1, 1'b1, 32'h8000_0001});

    directed(32'hFF, 32'h1, 1'b0, 0, 32'h100, 1'b0, 1'b0);
    clr_stats = 1'b1;
    @(posedge clk); #1;
    clr_stats = 1'b0;
    directed(32'hFF, 32'h1, 1'b0, 8, 32'hFF, 1'b0, 1'b1);
    chk("cnt_after_k8", {txn_count, err_count}, {4'd1, 4'd1});
    directed(32'd10, 32'd3, 1'b1, 0, 32'h7, 1'b1, 1'b0);
    directed(32'd10, 32'd3, 1'b1, 4, 32'hF, 1'b1, 1'b1);
    directed(32'h8000_0001, 32'h8000_0000, 1'b0, 63, 32'h8000_0001, 1'b1, 1'b1);

    // Random stream with random backpressure and bubbles
    sent = 0;
    cyc  = 0;
    while (sent < 16 && cyc < 600) begin
      out_ready = 1'($urandom_range(0, 1));
      if (!in_valid && $urandom_range(0, 3) != 0)
        drive($urandom, $urandom, 1'($urandom_range(0, 1)), int'($urandom_range(0, 40)));
      @(negedge clk);
      acc = in_valid && in_ready;
      if (acc) sent++;
      @(posedge clk); #1;
      if (acc) in_valid = 1'b0;
      cyc++;
    end
    in_valid = 1'b0;
    chk("stream_sent", sent, 16);
    out_ready = 1'b1;
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("stream_drain", exp_q.size(), 0);

    // Saturation
    clr_stats = 1'b1;
    @(posedge clk); #1;
    clr_stats = 1'b0;
    for (int i = 0; i < 20; i++) begin
      drive(32'hFF, 32'h1, 1'b0, 8);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("sat_counts", {txn_count, err_count}, {4'hF, 4'hF});

    // Clear coincident with a handshake
    drive(32'hFF, 32'h1, 1'b0, 8);
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("clr_wait", out_valid, 1);
    clr_stats = 1'b1;
    @(posedge clk); #1;
    clr_stats = 1'b0;
    chk("clr_on_hs", {txn_count, err_count}, 8'h00);

    // Reset with beats in flight
    for (int i = 0; i < 5; i++) begin
      drive($urandom, $urandom, 1'b0, 8);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("pre_rst_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_counts", {txn_count, err_count}, 8'h00);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("stale_out", out_valid, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
